// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: the sequencer state
// encoding, the address-width helper and the default geometry that the
// decode and write-back stages also use.
package regfile_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 32;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Address width for a power-of-two depth.
    function automatic int calc_aw(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// Init sequencer for regfile_mp. After every reset it walks idx from 0 to
// DEPTH-1, strobing one init write per edge, then enters RUN and raises
// ready on the edge that writes the last entry. The state is exported so
// the top and any bound checker can observe it directly.
module regfile_init_seq
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW   = calc_aw(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    output state_t        state,
    output logic          ready,
    output logic          init_we,
    output logic [AW-1:0] init_addr
);

    logic [AW-1:0] idx;
    logic [AW-1:0] idx_next;
    logic          ready_next;
    state_t        state_next;

    // State, index and ready registers; reset restarts the sweep at entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
            idx   <= '0;
            ready <= 1'b0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            ready <= ready_next;
        end
    end

    // Next-state logic: step through the array in INIT, hold in RUN.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        ready_next = ready;
        case (state)
            ST_INIT: begin
                idx_next = idx + AW'(1);
                if (idx == AW'(DEPTH - 1)) begin
                    state_next = ST_RUN;
                    ready_next = 1'b1;
                    idx_next   = '0;
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_INIT;
                idx_next   = '0;
                ready_next = 1'b0;
            end
        endcase
    end

    // The init write is suppressed on a reset edge so the array is untouched.
    assign init_we   = (state == ST_INIT) && !rst;
    assign init_addr = idx;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file for the decode stage. Configurable depth, width
// and port counts, self-clearing init to RESET_VAL, port 1 wins same-address
// write collisions, optional hardwired-zero entry 0 and a never-bypassed
// debug read port. Build option: define REGFILE_BYPASS_EN to forward
// same-cycle write data to the architectural read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               DEPTH     = DEFAULT_DEPTH,
    parameter int               NUM_RD    = 2,
    parameter int               NUM_WR    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(32'h0000_000A),
    parameter int               ZERO_REG  = 1,
    localparam int              AW        = calc_aw(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_WR-1:0]       wr_en,
    input  logic [NUM_WR*AW-1:0]    wr_addr,
    input  logic [NUM_WR*WIDTH-1:0] wr_data,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    input  logic [AW-1:0]           dbg_addr,
    output logic [WIDTH-1:0]        dbg_data,
    output logic                    ready
);

    logic [WIDTH-1:0] mem [DEPTH];
    state_t           state;
    logic             init_we;
    logic [AW-1:0]    init_addr;
    logic             wr_ok;

    regfile_init_seq #(
        .DEPTH (DEPTH)
    ) u_init_seq (
        .clk       (clk),
        .rst       (rst),
        .state     (state),
        .ready     (ready),
        .init_we   (init_we),
        .init_addr (init_addr)
    );

    // Normal writes only count in RUN and never on a reset edge.
    assign wr_ok = (state == ST_RUN) && !rst;

    // Array update: init sweep owns the array in INIT; in RUN the ports are
    // applied in ascending order so the highest-numbered port wins a collision.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_addr] <= RESET_VAL;
        end else if (wr_ok) begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_en[p] &&
                    !((ZERO_REG != 0) && (wr_addr[p*AW +: AW] == '0))) begin
                    mem[wr_addr[p*AW +: AW]] <= wr_data[p*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Architectural reads: zero until ready, zero for entry 0 when hardwired,
    // otherwise stored data (or forwarded write data in the bypass build).
    always_comb begin
        rd_data = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            if (ready && !((ZERO_REG != 0) && (rd_addr[r*AW +: AW] == '0))) begin
                rd_data[r*WIDTH +: WIDTH] = mem[rd_addr[r*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                for (int p = 0; p < NUM_WR; p++) begin
                    if (wr_ok && wr_en[p] &&
                        (wr_addr[p*AW +: AW] == rd_addr[r*AW +: AW])) begin
                        rd_data[r*WIDTH +: WIDTH] = wr_data[p*WIDTH +: WIDTH];
                    end
                end
`endif
            end
        end
    end

    // Debug read always shows stored contents, never forwarded data.
    always_comb begin
        dbg_data = '0;
        if (ready && !((ZERO_REG != 0) && (dbg_addr == '0))) begin
            dbg_data = mem[dbg_addr];
        end
    end

endmodule
